ibis_voice_scheduler: RTL
=========================

Name: ibis_voice_scheduler

Overview:
- Time-multiplexed bank of VOICES down-counting phase accumulators sharing one decrementer.
- Each `tick` (sample strobe) starts a sweep that services every voice once, in index order, one voice per cycle.
- A voice that sits at zero with a non-zero period reloads and posts its index to an event FIFO.
- Sits between the host register interface and the envelope/oscillator trigger logic.

Parameters:
- WIDTH, 16, phase/period width in bits.
- VOICES, 8, number of voice slots (>=2).
- VIDX_W, $clog2(VOICES), voice index width (derived, not overridden).
- FIFO_DEPTH, 4, event FIFO entries (power of two, >=2).

Ports:
- aclk  in  1  clock, rising edge.
- areset  in  1  asynchronous active-high reset.
- tick  in  1  single-cycle sweep start strobe.
- cfg_valid  in  1  config write request.
- cfg_ready  out  1  config accept; constant 1 out of reset.
- cfg_voice  in  VIDX_W  target voice.
- cfg_period  in  WIDTH  reload value; 0 disables the voice.
- cfg_retrigger  in  1  also schedule a phase reload on the next service of the voice.
- evt_valid  out  1  event FIFO not empty.
- evt_ready  in  1  consumer accepts the head event.
- evt_voice  out  VIDX_W  voice index at the FIFO head.
- busy  out  1  sweep in progress.
- tick_overrun  out  1  sticky: a tick arrived while busy.
- evt_overflow  out  1  sticky: an event was dropped because the FIFO was full.
- clear_status  in  1  clears both sticky flags.

Behaviour:
- Reset (asynchronous, active-high):
  - All phase[], period[] and pending[] registers go to 0.
  - FIFO is empty, state is IDLE, voice index is 0.
  - Outputs: busy=0, evt_valid=0, evt_voice=0, tick_overrun=0, evt_overflow=0, cfg_ready=0 while areset is high, then 1.
- FSM:
  - IDLE: on tick, go to SWEEP with idx=0.
  - SWEEP: service voice idx each cycle and increment idx. After servicing idx=VOICES-1, return to IDLE.
  - A sweep lasts exactly VOICES cycles. busy=1 iff in SWEEP.
  - A tick received in SWEEP is ignored and sets tick_overrun. It is not queued.
- Service of voice v, in priority order:
  1. pending[v]=1: phase[v]<=period[v], clear pending[v], no event.
  2. Else phase[v]!=0: phase[v]<=phase[v]-1. Decrement never wraps.
  3. Else phase[v]==0 and period[v]!=0: phase[v]<=period[v] and push v into the FIFO.
  4. Else phase[v]==0 and period[v]==0: no change, no event.
- Resulting event period for voice v is period+1 ticks.
- Config write (cfg_valid & cfg_ready): period[cfg_voice]<=cfg_period. If cfg_retrigger, pending[cfg_voice]<=1. Accepted in IDLE or SWEEP.
- Write collision (config targets the voice serviced in the same cycle):
  - That service uses the old period and the old pending value.
  - The new period lands in the register.
  - A pending set by the write survives until the next sweep. The service's own clear of pending loses to the write's set.
- Event FIFO:
  - FIFO_DEPTH entries; evt_voice/evt_valid come from the registered head, standard valid/ready.
  - Pop on evt_valid & evt_ready.
  - A push when full is allowed only if a pop happens in the same cycle. Otherwise the event is dropped, evt_overflow sets, and the voice still reloads.
  - Events enter the FIFO in voice index order within a sweep.
  - First event is visible on evt_valid the cycle after its service cycle.
- Sticky flags:
  - clear_status clears both flags.
  - If a set condition and clear_status occur in the same cycle, the set wins.
- Reset asserted mid-sweep aborts the sweep immediately and applies all reset values. Events already in the FIFO are lost.
- Arithmetic: unsigned WIDTH bits throughout. period=2^WIDTH-1 must work.

Test Plan:
- Reset then voice2 period=3, ticks spaced 20 cycles:
  - Expect evt_voice=2 after sweep 1, then after sweeps 5, 9, 13.
  - Expect no event from any other voice.
- Voices 0, 5, 7 all period=0 except write 5 with period=1:
  - Expect events for voice 5 only, on every 2nd sweep.
  - busy is high exactly 8 cycles per tick.
- Tick asserted on cycle 3 of a sweep:
  - Expect tick_overrun=1 and no extra sweep.
  - clear_status with no new overrun returns it to 0.
- All 8 voices period=0 then 1, evt_ready=0:
  - First sweep yields 4 events; voices 4..7 are dropped and evt_overflow=1.
  - Then evt_ready=1 drains voices 0,1,2,3 in order.
- Voice3 phase counting down from 100, write period=10 with cfg_retrigger during the cycle voice3 is serviced:
  - That service decrements to 99.
  - Next sweep loads 10 with no event.
  - An event follows 11 sweeps later.
- areset pulsed in mid-sweep with 2 events queued:
  - busy=0, evt_valid=0 and all flags 0 immediately.
  - Next tick gives a full 8-cycle sweep with no events until periods are rewritten.

Source files
------------

// File: rtl/ibis_voice_scheduler.sv
// ibis_voice_scheduler
//   A time-multiplexed bank of VOICES down-counting phase accumulators that
//   share one decrementer. Each tick starts a sweep that services every voice
//   once, in index order, one voice per cycle. A voice sitting at zero with a
//   non-zero period reloads and posts its index to a small event FIFO.
//
// Ports
//   aclk, areset      clock (rising edge), asynchronous active-high reset
//   tick              single-cycle sweep start strobe
//   cfg_valid/ready   config write handshake (ready is 1 once out of reset)
//   cfg_voice         target voice of the config write
//   cfg_period        reload value; 0 disables the voice
//   cfg_retrigger     force a phase reload on the next service of the voice
//   evt_valid/ready   event FIFO head handshake
//   evt_voice         voice index at the FIFO head
//   busy              sweep in progress
//   tick_overrun      sticky: tick seen while busy
//   evt_overflow      sticky: event dropped on a full FIFO
//   clear_status      clears both sticky flags (a same-cycle set wins)
module ibis_voice_scheduler #(
  parameter  int unsigned WIDTH      = 16,
  parameter  int unsigned VOICES     = 8,
  parameter  int unsigned FIFO_DEPTH = 4,
  localparam int unsigned VIDX_W     = $clog2(VOICES)
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              tick,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [VIDX_W-1:0] cfg_voice,
  input  logic [WIDTH-1:0]  cfg_period,
  input  logic              cfg_retrigger,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [VIDX_W-1:0] evt_voice,
  output logic              busy,
  output logic              tick_overrun,
  output logic              evt_overflow,
  input  logic              clear_status
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [VIDX_W-1:0] LAST_IDX = VIDX_W'(VOICES - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic {
    ST_IDLE,
    ST_SWEEP
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [VIDX_W-1:0] r_idx;
  logic [VIDX_W-1:0] w_idx_nxt;

  logic [WIDTH-1:0]  r_phase  [VOICES];
  logic [WIDTH-1:0]  r_period [VOICES];
  logic [VOICES-1:0] r_pending;

  logic              r_cfg_ready;
  logic              r_tick_overrun;
  logic              r_evt_overflow;

  logic [VIDX_W-1:0] r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_svc;
  logic              w_cfg_wr;
  logic [WIDTH-1:0]  w_cur_phase;
  logic [WIDTH-1:0]  w_cur_period;
  logic              w_cur_pending;
  logic [WIDTH-1:0]  w_phase_nxt;
  logic              w_pend_clr;
  logic              w_push;
  logic              w_full;
  logic              w_pop;
  logic              w_fifo_wr;
  logic              w_drop;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      ST_IDLE: begin
        if (tick) begin
          w_state_nxt = ST_SWEEP;
          w_idx_nxt   = '0;
        end
      end
      ST_SWEEP: begin
        if (r_idx == LAST_IDX) begin
          w_state_nxt = ST_IDLE;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + VIDX_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = '0;
      end
    endcase
  end

  assign busy  = (r_state == ST_SWEEP);
  assign w_svc = busy;

  // ------------------------------------------------------ voice service
  assign w_cur_phase   = r_phase[r_idx];
  assign w_cur_period  = r_period[r_idx];
  assign w_cur_pending = r_pending[r_idx];

  always_comb begin
    w_phase_nxt = w_cur_phase;
    w_pend_clr  = 1'b0;
    w_push      = 1'b0;
    if (w_svc) begin
      if (w_cur_pending) begin
        w_phase_nxt = w_cur_period;
        w_pend_clr  = 1'b1;
      end else if (w_cur_phase != '0) begin
        w_phase_nxt = w_cur_phase - WIDTH'(1);
      end else if (w_cur_period != '0) begin
        w_phase_nxt = w_cur_period;
        w_push      = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int unsigned v = 0; v < VOICES; v++) begin
        r_phase[v] <= '0;
      end
    end else if (w_svc) begin
      r_phase[r_idx] <= w_phase_nxt;
    end
  end

  // ------------------------------------------------------- config path
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_cfg_ready <= 1'b0;
    end else begin
      r_cfg_ready <= 1'b1;
    end
  end

  assign cfg_ready = r_cfg_ready;
  assign w_cfg_wr  = cfg_valid & r_cfg_ready;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int unsigned v = 0; v < VOICES; v++) begin
        r_period[v] <= '0;
      end
    end else if (w_cfg_wr) begin
      r_period[cfg_voice] <= cfg_period;
    end
  end

  // A retrigger write to the voice being serviced must outlive that
  // service's own clear, so the set is checked first.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_pending <= '0;
    end else begin
      for (int unsigned v = 0; v < VOICES; v++) begin
        if (w_cfg_wr && cfg_retrigger && (cfg_voice == VIDX_W'(v))) begin
          r_pending[v] <= 1'b1;
        end else if (w_pend_clr && (r_idx == VIDX_W'(v))) begin
          r_pending[v] <= 1'b0;
        end
      end
    end
  end

  // -------------------------------------------------------- event FIFO
  assign w_full    = (r_count == FULL_CNT);
  assign evt_valid = (r_count != '0);
  assign w_pop     = evt_valid & evt_ready;
  assign w_fifo_wr = w_push & (~w_full | w_pop);
  assign w_drop    = w_push & w_full & ~w_pop;
  assign evt_voice = r_fifo[r_rptr];

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo[i] <= '0;
      end
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_fifo_wr) begin
        r_fifo[r_wptr] <= r_idx;
        r_wptr         <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      case ({w_fifo_wr, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ------------------------------------------------------ sticky flags
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_tick_overrun <= 1'b0;
      r_evt_overflow <= 1'b0;
    end else begin
      r_tick_overrun <= (tick & busy) | (r_tick_overrun & ~clear_status);
      r_evt_overflow <= w_drop        | (r_evt_overflow & ~clear_status);
    end
  end

  assign tick_overrun = r_tick_overrun;
  assign evt_overflow = r_evt_overflow;

endmodule
